// File: rtl/data_memory_be_if.sv
// Request/response bundle between the MEM stage (master) and the byte-enable data memory (slave).
// Carries the valid/ready request, the registered read response and the out-of-range flag.
interface data_memory_be_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    localparam int NBE = DATA_WIDTH / 8;

    logic                  req;
    logic                  we;
    logic [NBE-1:0]        be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] q;
    logic                  err;

    modport master (
        output req, we, be, addr, data,
        input  ready, rvalid, q, err
    );

    modport slave (
        input  req, we, be, addr, data,
        output ready, rvalid, q, err
    );
endinterface

// File: rtl/data_memory_be.sv
// Single-port word memory with byte-lane writes and a 1-cycle registered read; reset zeroes one word per cycle.
// ready is low while clearing (requests ignored), otherwise always high; out-of-range requests pulse err.
module data_memory_be #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic            clk,
    input  logic            rst,
    data_memory_be_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int NBE   = DATA_WIDTH / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IDX_W-1:0]      clr_ptr;
    logic                  clr_last;

    logic [DATA_WIDTH-1:0] ram [MEM_DEPTH];

    logic                  accept;
    logic                  out_of_range;
    logic [IDX_W-1:0]      idx;
    logic                  wr_en;
    logic                  rd_en;

    logic                  rvalid_reg;
    logic                  err_reg;
    logic [DATA_WIDTH-1:0] q_reg;

    assign clr_last = (clr_ptr == IDX_W'(MEM_DEPTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_last) state_next = IDLE;
            IDLE:    state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + IDX_W'(1);
            end
        end
    end

    assign bus.ready = (state == IDLE);

    // Requests arriving in a reset cycle are dropped even if the FSM still shows IDLE.
    assign accept       = bus.req & bus.ready & ~rst;
    assign idx          = bus.addr[IDX_W-1:0];
    assign out_of_range = |(bus.addr >> IDX_W);
    assign wr_en        = accept & bus.we & ~out_of_range;
    assign rd_en        = accept & ~bus.we;

    // The array has no reset; the clear engine and the request port share the single write port.
    always_ff @(posedge clk) begin
        if (!rst && state == CLEAR) begin
            ram[clr_ptr] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NBE; k++) begin
                if (bus.be[k]) begin
                    ram[idx][8*k +: 8] <= bus.data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
            q_reg      <= '0;
        end else begin
            rvalid_reg <= rd_en;
            err_reg    <= accept & out_of_range;
            if (rd_en) begin
                q_reg <= out_of_range ? '0 : ram[idx];
            end
        end
    end

    assign bus.rvalid = rvalid_reg;
    assign bus.err    = err_reg;
    assign bus.q      = q_reg;
endmodule

// File: tb/tb_data_memory_be.sv
// Directed bench for data_memory_be: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_data_memory_be;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_memory_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    data_memory_be #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic        rv;
        logic        er;
        logic [15:0] q;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rvalid === 1'b1 || bus.err === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_response actual=rvalid%0b/err%0b required=none",
                             bus.rvalid, bus.err);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (bus.rvalid !== e.rv || bus.err !== e.er ||
                        (e.rv && bus.q !== e.q)) begin
                        errors++;
                        $display("FAIL response actual=rv%0b err%0b q=%h required=rv%0b err%0b q=%h",
                                 bus.rvalid, bus.err, bus.q, e.rv, e.er, e.q);
                    end
                end
            end
        end
    end

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] b,
                            input logic exp_err);
        bus.req  = 1'b1;
        bus.we   = 1'b1;
        bus.be   = b;
        bus.addr = a;
        bus.data = d;
        if (exp_err) sb.push_back('{rv: 1'b0, er: 1'b1, q: 16'h0000});
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] exp_q, input logic exp_err);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.be   = 2'b00;
        bus.addr = a;
        sb.push_back('{rv: 1'b1, er: exp_err, q: exp_q});
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    task automatic do_reset(input int n, input string name);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        check({name, "_ready"},  {31'b0, bus.ready},  32'd0);
        check({name, "_rvalid"}, {31'b0, bus.rvalid}, 32'd0);
        check({name, "_err"},    {31'b0, bus.err},    32'd0);
        check({name, "_q"},      {16'b0, bus.q},      32'd0);
        rst = 1'b0;
    endtask

    // Counts posedges from reset release until ready is seen high.
    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.ready !== 1'b1 && n < 3 * DEPTH) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, DEPTH);
    endtask

    initial begin
        rst      = 1'b1;
        bus.req  = 1'b0;
        bus.we   = 1'b0;
        bus.be   = 2'b00;
        bus.addr = '0;
        bus.data = '0;
        @(posedge clk);
        #1;

        // 1: clear timing and cleared contents
        do_reset(2, "rst1");
        wait_ready("clear_cycles1");
        do_read(16'd0,    16'h0000, 1'b0);
        do_read(16'd511,  16'h0000, 1'b0);
        do_read(16'd1023, 16'h0000, 1'b0);

        // 2: full write, then read on the very next cycle
        do_write(16'd5, 16'hABCD, 2'b11, 1'b0);
        do_read(16'd5, 16'hABCD, 1'b0);

        // 3: low-lane write merges, empty enable changes nothing
        do_write(16'd5, 16'h1234, 2'b01, 1'b0);
        do_read(16'd5, 16'hAB34, 1'b0);
        do_write(16'd5, 16'hFFFF, 2'b00, 1'b0);
        do_read(16'd5, 16'hAB34, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("q_hold", {16'b0, bus.q}, 32'h0000AB34);
        check("rvalid_idle", {31'b0, bus.rvalid}, 32'd0);
        do_write(16'h0100, 16'h00C3, 2'b10, 1'b0);
        do_write(16'h0100, 16'h5A00, 2'b10, 1'b0);
        do_read(16'h0100, 16'h5A00, 1'b0);

        // 4: out-of-range write is suppressed, out-of-range read returns zero
        do_write(16'h0400, 16'hFFFF, 2'b11, 1'b1);
        do_read(16'h0000, 16'h0000, 1'b0);
        do_read(16'h0400, 16'h0000, 1'b1);
        do_read(16'h8005, 16'h0000, 1'b1);
        do_read(16'd5, 16'hAB34, 1'b0);

        // 5: reset mid-clear restarts the sweep
        do_write(16'd0, 16'd1, 2'b11, 1'b0);
        do_write(16'd1, 16'd2, 2'b11, 1'b0);
        do_write(16'd2, 16'd3, 2'b11, 1'b0);
        do_write(16'd3, 16'd4, 2'b11, 1'b0);
        do_read(16'd3, 16'd4, 1'b0);
        do_read(16'd2, 16'd3, 1'b0);
        @(posedge clk);
        #1;
        do_reset(2, "rst2");
        repeat (100) @(posedge clk);
        #1;
        check("ready_mid_clear", {31'b0, bus.ready}, 32'd0);
        do_reset(1, "rst3");
        wait_ready("clear_cycles_restart");
        do_read(16'd0, 16'h0000, 1'b0);
        do_read(16'd1, 16'h0000, 1'b0);
        do_read(16'd2, 16'h0000, 1'b0);
        do_read(16'd3, 16'h0000, 1'b0);

        // 6: request held through the clear is ignored until ready rises
        do_reset(2, "rst4");
        bus.req  = 1'b1;
        bus.we   = 1'b1;
        bus.be   = 2'b11;
        bus.addr = 16'd1000;
        bus.data = 16'h5555;
        wait_ready("clear_cycles_req_held");
        bus.addr = 16'd1001;
        bus.data = 16'h7777;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        do_read(16'd1000, 16'h0000, 1'b0);
        do_read(16'd1001, 16'h7777, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
